// File: rtl/dut_clkrst_gen.sv
// rtl/dut_clkrst_gen.sv - divided DUT clocks with run/halt/step modes and sequenced DUT reset
module dut_clkrst_gen #(
  parameter int NUM_CLK        = 2,
  parameter int DIV_W          = 16,
  parameter int DIV_DEFAULT    = 6000,
  parameter int RST_DUT_CYCLES = 4
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic [NUM_CLK*DIV_W-1:0] div_val,
  input  logic [NUM_CLK-1:0]       div_load,
  input  logic [1:0]               mode,
  input  logic                     step,
  input  logic                     soft_rst,
  output logic [NUM_CLK-1:0]       clk_dut,
  output logic [NUM_CLK-1:0]       clk_dut_rise,
  output logic                     rst_dut,
  output logic                     busy
);

  localparam logic [1:0]       MODE_RUN    = 2'b00;
  localparam logic [1:0]       MODE_STEP   = 2'b10;
  localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_DEFAULT);
  localparam logic [7:0]       RST_CNT_END = 8'(RST_DUT_CYCLES);

  logic [1:0]         sync_q;
  logic               rst_sync_n;

  logic [DIV_W-1:0]   cnt  [NUM_CLK];
  logic [DIV_W-1:0]   div  [NUM_CLK];
  logic [DIV_W-1:0]   pend [NUM_CLK];
  logic [NUM_CLK-1:0] pend_v;
  logic [NUM_CLK-1:0] ch_act;
  logic [NUM_CLK-1:0] run_en;
  logic [NUM_CLK-1:0] at_end;
  logic [NUM_CLK-1:0] step_done;

  logic               step_q;
  logic               step_go;
  logic               clk0_q;
  logic               clk0_fall;
  logic [7:0]         rst_cnt;

  // Assert asynchronously, release two CLK edges after rst_n rises
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[1];

  // Per-channel enables: a step period always completes; otherwise run mode
  // free-runs and halt/idle-step only lets a high phase finish
  always_comb begin
    step_go   = (mode == MODE_STEP) && !busy && step && !step_q;
    at_end    = '0;
    step_done = '0;
    run_en    = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      at_end[i]    = (cnt[i] == div[i]);
      step_done[i] = ch_act[i] && !clk_dut[i] && at_end[i];
      if (ch_act[i]) begin
        run_en[i] = 1'b1;
      end else if (busy) begin
        run_en[i] = 1'b0;
      end else if (mode == MODE_RUN) begin
        run_en[i] = 1'b1;
      end else begin
        run_en[i] = clk_dut[i];
      end
    end
  end

  // Divider counters, clock toggles and deferred divider loads
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        cnt[i]  <= '0;
        div[i]  <= DIV_RST;
        pend[i] <= '0;
      end
      pend_v       <= '0;
      ch_act       <= '0;
      clk_dut      <= '0;
      clk_dut_rise <= '0;
    end else begin
      clk_dut_rise <= '0;
      for (int i = 0; i < NUM_CLK; i++) begin
        if (step_go) begin
          // A step period starts with the high phase and a fresh count
          cnt[i]          <= '0;
          clk_dut[i]      <= 1'b1;
          clk_dut_rise[i] <= !clk_dut[i];
          ch_act[i]       <= 1'b1;
          if (pend_v[i]) begin
            div[i]    <= pend[i];
            pend_v[i] <= 1'b0;
          end
        end else if (step_done[i]) begin
          // Low phase of the step period is over: freeze without toggling
          cnt[i]    <= '0;
          ch_act[i] <= 1'b0;
        end else if (run_en[i]) begin
          if (at_end[i]) begin
            cnt[i]          <= '0;
            clk_dut[i]      <= !clk_dut[i];
            clk_dut_rise[i] <= !clk_dut[i];
            if (pend_v[i]) begin
              div[i]    <= pend[i];
              pend_v[i] <= 1'b0;
            end
          end else begin
            cnt[i] <= cnt[i] + DIV_W'(1);
          end
        end
        // A load coinciding with a toggle stays pending for the next toggle
        if (div_load[i]) begin
          pend[i]   <= div_val[i*DIV_W +: DIV_W];
          pend_v[i] <= 1'b1;
        end
      end
    end
  end

  // Step request edge detection and busy flag
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      step_q <= 1'b0;
      busy   <= 1'b0;
    end else begin
      step_q <= step;
      busy   <= step_go || (|(ch_act & ~step_done));
    end
  end

  assign clk0_fall = clk0_q && !clk_dut[0];

  // DUT reset sequencer: count channel-0 rises, release after the next fall
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clk0_q  <= 1'b0;
      rst_dut <= 1'b1;
      rst_cnt <= '0;
    end else begin
      clk0_q <= clk_dut[0];
      if (soft_rst) begin
        rst_dut <= 1'b1;
        rst_cnt <= '0;
      end else if (rst_dut) begin
        if (clk_dut_rise[0] && (rst_cnt != RST_CNT_END)) begin
          rst_cnt <= rst_cnt + 8'd1;
        end
        if (clk0_fall && (rst_cnt == RST_CNT_END)) begin
          rst_dut <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/dut_clkrst_gen.md
# dut_clkrst_gen

Parametrised clock and reset generator for board-level test harnesses. It sits between the board oscillator and the user DUT. It produces NUM_CLK independently divided DUT clocks with runtime-programmable dividers, run/halt/single-step modes, and a DUT reset that is released after a set number of DUT clock edges. It replaces the fixed divider and fixed reset-delay counter used in earlier board tops.

## Interface
- NUM_CLK, 2, number of divided clock channels (1..8)
- DIV_W, 16, divider register width per channel
- DIV_DEFAULT, 6000, per-channel divider value loaded at reset; half period = div+1 CLK cycles
- RST_DUT_CYCLES, 4, clk_dut[0] rising edges during which rst_dut is held after reset release (1..255)

- CLK  in  1  board clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- div_val  in  NUM_CLK*DIV_W  per-channel divider; channel i at [i*DIV_W +: DIV_W]
- div_load  in  NUM_CLK  per-channel load strobe for div_val
- mode  in  2  00 run, 01 halt, 10 step, 11 treated as halt
- step  in  1  step request, rising-edge sensitive
- soft_rst  in  1  synchronous re-run of the DUT reset sequence
- clk_dut  out  NUM_CLK  divided clocks, registered
- clk_dut_rise  out  NUM_CLK  one-CLK strobe, high in the same cycle clk_dut[i] first reads 1
- rst_dut  out  1  active-high DUT reset, registered
- busy  out  1  step in progress

## Operation
- Reset assertion is asynchronous. Deassertion passes through an internal 2-flop synchroniser, so logic leaves reset on the 2nd CLK edge after rst_n rises.
- Reset values: clk_dut=0, clk_dut_rise=0, rst_dut=1, busy=0, all counters 0, every div=DIV_DEFAULT, no pending loads.
- Per-channel counter cnt (DIV_W bits):
  - When running, if cnt==div, toggle clk_dut[i] and set cnt<=0; otherwise cnt<=cnt+1.
  - div=0 gives CLK/2.
- Divider load:
  - div_load[i] captures div_val into a pending register.
  - The pending value is applied at that channel's next toggle, so no runt phase is produced.
  - A second load before it is applied overwrites the pending value.
- Run (00): all channels free-run.
- Halt (01/11):
  - A channel that is low freezes immediately, with cnt held.
  - A channel that is high finishes its high phase, toggles low, then freezes.
- Step (10), channels halted low:
  - A rising edge on step (previous-cycle sampled) sets busy=1 the next cycle.
  - Each channel then produces exactly one period: high for div+1 cycles, low for div+1 cycles, starting with cnt=0. It then freezes.
  - busy clears in the cycle after the last channel completes.
  - Step edges while busy, or while mode≠10, are ignored.
  - Leaving step mode while busy: outstanding periods complete, then the new mode applies.
- Reset sequencer (8-bit edge counter):
  - Counts clk_dut_rise[0] while rst_dut=1.
  - After the RST_DUT_CYCLES-th rise, rst_dut drops in the CLK cycle following the next falling edge of clk_dut[0].
  - While halted, the count advances only via steps.
- soft_rst=1:
  - rst_dut<=1 next cycle and the edge counter clears.
  - The sequence re-runs once soft_rst is low.
  - Clocks and dividers are not disturbed.
- rst_n asserted mid-step or mid-sequence: immediate return to reset values.

## Timing
- First edge after synchronised release: clk_dut[i] reads 1 after CLK edge div (edges numbered from 0).
- Period = 2*(div+1) CLK cycles; duty cycle exactly 50%.
- clk_dut_rise is registered alongside clk_dut, with zero relative skew.
- Mode changes take effect at the next CLK edge, subject to the halt-low rule.
- Simultaneous div_load and toggle in the same cycle: the new value is applied at the following toggle.
- Simultaneous soft_rst and rst_dut release: soft_rst wins and rst_dut stays 1.

## Test plan
- DIV_DEFAULT=3, RST_DUT_CYCLES=4, mode=00, release rst_n -> clk_dut[0] period 8 CLK, 4 high/4 low. rst_dut falls 1 cycle after the 4th falling edge.
- Load div_val=1 on channel 1 mid high-phase -> current phase keeps 4 cycles, then period 4. Channel 0 unaffected.
- Switch to halt while clk_dut[0] is high -> it stays high for its remaining phase, then holds low indefinitely with clk_dut_rise=0.
- Mode 10, step pulse held high for 20 cycles -> exactly one period per channel, busy high for the longest 2*(div+1) span, no second period.
- Pulse soft_rst after rst_dut=0 -> rst_dut=1 next cycle, released again after 4 more clk_dut[0] rises. Clock phase is continuous.
- Assert rst_n low mid-step -> all outputs at reset values immediately, without waiting for a CLK edge. Release gives a fresh sequence with div=DIV_DEFAULT.
